text_console: RTL and testbench
===============================

// Module: text_console
// PURPOSE
// - Byte-stream terminal front end sitting directly upstream of the video unit's text RAM (TRAM) write port.
// - Accepts characters over a valid/ready handshake and tracks a cursor.
// - Writes glyph codes into TRAM; handles the control codes below, including scroll-up and clear-screen.
// - Turns CPU/UART output into a scrolling 80x30 text display.
// PARAMETERS
// - COLS        80     characters per row (640 px / 8 px)
// - ROWS        30     rows per screen (480 px / 16 px)
// - FILL_CHAR   8'h20  code written by clears and backspace
// - CLR_ON_RST  1      1: full-screen clear after reset before first accept; 0: none
// PORTS
// - sys_clk       in   1   single clock; all logic on posedge
// - rst_n         in   1   synchronous, active-low reset
// - char_data     in   8   incoming character code
// - char_valid    in   1   char_data valid
// - char_ready    out  1   block can accept this cycle
// - tram_addr     out  AW  TRAM address, AW = $clog2(ROWS*COLS) (12 by default)
// - tram_wdata    out  8   TRAM write data
// - tram_wenable  out  1   TRAM write strobe
// - tram_rdata    in   8   TRAM read data, valid 1 cycle after tram_addr (registered read)
// - cursor_row    out  5   current row, 0..ROWS-1
// - cursor_col    out  7   current column, 0..COLS-1
// - busy          out  1   scroll or clear in progress
// BEHAVIOUR
// - All outputs are registered.
// - Reset values: tram_wenable=0, tram_addr=0, tram_wdata=0, char_ready=0, busy=CLR_ON_RST, cursor=(0,0).
// - Reset asserted mid-scroll or mid-clear aborts the operation immediately; no further writes are issued.
// - Handshake:
//   - Accept occurs when char_valid & char_ready at cycle T.
//   - char_ready is high only in IDLE; it drops at T+1.
//   - char_data is don't-care while char_ready=0.
// - FSM states: IDLE, PUT, SCROLL_RD, SCROLL_WR, CLEAR.
//   - CLEAR_ALL is the CLEAR state with base=0 and count=ROWS*COLS.
// - Printable codes (anything not listed below):
//   - At T+1: tram_wenable=1, tram_addr=row*COLS+col, tram_wdata=code.
//   - col is then incremented.
//   - If col reaches COLS: col=0 and a newline is applied.
//   - Back in IDLE (char_ready=1) at T+2 unless a scroll is triggered.
// - 8'h0A LF: col=0, row+1. No TRAM write.
// - 8'h0D CR: col=0. No TRAM write.
// - 8'h08 BS: if col>0, col-1 and write FILL_CHAR at the new position; at col=0, no-op (no wrap to previous row).
// - 8'h0C FF: enter CLEAR_ALL, then cursor=(0,0).
// - Newline on row=ROWS-1 triggers a scroll; row stays ROWS-1:
//   - For i = 0 .. (ROWS-1)*COLS-1:
//     - SCROLL_RD drives tram_addr=i+COLS.
//     - SCROLL_WR writes tram_rdata to addr i.
//   - Then CLEAR writes FILL_CHAR to addrs (ROWS-1)*COLS .. ROWS*COLS-1.
//   - Total 2*(ROWS-1)*COLS + COLS cycles (4720 by default). busy=1 throughout.
// - CLEAR_ALL: ROWS*COLS consecutive write cycles (2400 by default), addr ascending from 0.
// - Wrap-around:
//   - tram_addr never exceeds ROWS*COLS-1.
//   - Address math is done at AW bits; row*COLS is computed with a constant multiply, no overflow.
// - Simultaneous events:
//   - A printable char at (ROWS-1, COLS-1) writes first, then scrolls.
//   - The cursor ends at (ROWS-1, 0).
// - tram_wenable is high only in PUT, BS-write, SCROLL_WR and CLEAR cycles.
// - Read-only TRAM accesses (SCROLL_RD) drive tram_wenable=0.
// STRUCTURE
// - Shared package video_pkg holds:
//   - screen constants: WIDTH, HEIGHT, CHAR_WIDTH, CHAR_HEIGHT, COLS, ROWS, TRAM_SIZE, TRAM_AW;
//   - control code constants: CC_LF, CC_CR, CC_BS, CC_FF;
//   - the FSM state enum.
// - One sub-module, console_cursor:
//   - Holds the row/col registers.
//   - Provides advance, newline, cr and back operations.
//   - Outputs the linear address and a need_scroll flag.
// - The top level holds the FSM, the scroll/clear counter, and the TRAM port registers.
// TESTING
// - Reset with CLR_ON_RST=1 -> 2400 writes of 8'h20 to addrs 0..2399, busy=1 throughout; then char_ready=1, cursor=(0,0).
// - Send "Hi" (8'h48, 8'h69) -> writes 48@0 and 69@1; cursor_col=2; char_ready re-high 2 cycles after each accept.
// - Send 80 x 8'h41 then 8'h42 -> writes 41@0..79, then 42@80; cursor=(1,1).
// - At cursor (29,5) send 8'h0A:
//   - reads 80..2399 copied to 0..2319, then 2320..2399 written 8'h20;
//   - busy for 4720 cycles; cursor=(29,0).
// - Send 8'h08 at col=3 -> write 8'h20@(row*80+2), col=2; at col=0 -> no write, cursor unchanged.
// - Assert rst_n=0 during a scroll -> next cycle tram_wenable=0, cursor=(0,0), busy=1, and a new clear starts after release.
// - Use a TRAM model with 1-cycle read latency; a scoreboard compares the final 2400-byte image.

Source files
------------

// File: rtl/video_pkg.sv
// Screen geometry, control codes and shared enums for the text video path.
package video_pkg;

    localparam int unsigned WIDTH       = 640;
    localparam int unsigned HEIGHT      = 480;
    localparam int unsigned CHAR_WIDTH  = 8;
    localparam int unsigned CHAR_HEIGHT = 16;
    localparam int unsigned COLS        = WIDTH / CHAR_WIDTH;
    localparam int unsigned ROWS        = HEIGHT / CHAR_HEIGHT;
    localparam int unsigned TRAM_SIZE   = COLS * ROWS;
    localparam int unsigned TRAM_AW     = $clog2(TRAM_SIZE);

    localparam logic [7:0] CC_LF = 8'h0A;
    localparam logic [7:0] CC_CR = 8'h0D;
    localparam logic [7:0] CC_BS = 8'h08;
    localparam logic [7:0] CC_FF = 8'h0C;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PUT       = 3'd1,
        ST_SCROLL_RD = 3'd2,
        ST_SCROLL_WR = 3'd3,
        ST_CLEAR     = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        CUR_NONE    = 3'd0,
        CUR_ADVANCE = 3'd1,
        CUR_NEWLINE = 3'd2,
        CUR_CR      = 3'd3,
        CUR_BACK    = 3'd4,
        CUR_HOME    = 3'd5
    } cursor_op_e;

endpackage

// File: rtl/console_cursor.sv
// Cursor row/column registers with advance/newline/cr/back/home operations.
// The bottom row never increments; need_scroll flags when a newline would leave the screen.
module console_cursor
    import video_pkg::*;
#(
    parameter int unsigned COLS = video_pkg::COLS,
    parameter int unsigned ROWS = video_pkg::ROWS,
    parameter int unsigned AW   = $clog2(ROWS * COLS)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  cursor_op_e    i_op,
    output logic [4:0]    o_row,
    output logic [6:0]    o_col,
    output logic [AW-1:0] o_lin_addr,
    output logic          o_need_scroll
);

    localparam logic [6:0]    L_COL_LAST = 7'(COLS - 1);
    localparam logic [4:0]    L_ROW_LAST = 5'(ROWS - 1);
    localparam logic [AW-1:0] L_COLS_AW  = AW'(COLS);

    logic [4:0] r_row;
    logic [6:0] r_col;

    // Cursor position update
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_row <= 5'd0;
            r_col <= 7'd0;
        end else begin
            case (i_op)
                CUR_ADVANCE: begin
                    if (r_col == L_COL_LAST) begin
                        r_col <= 7'd0;
                        if (r_row != L_ROW_LAST) r_row <= r_row + 5'd1;
                    end else begin
                        r_col <= r_col + 7'd1;
                    end
                end
                CUR_NEWLINE: begin
                    r_col <= 7'd0;
                    if (r_row != L_ROW_LAST) r_row <= r_row + 5'd1;
                end
                CUR_CR:   r_col <= 7'd0;
                CUR_BACK: if (r_col != 7'd0) r_col <= r_col - 7'd1;
                CUR_HOME: begin
                    r_row <= 5'd0;
                    r_col <= 7'd0;
                end
                default: begin
                    r_row <= r_row;
                    r_col <= r_col;
                end
            endcase
        end
    end

    // Scroll request for the operation currently being applied
    always_comb begin
        o_need_scroll = 1'b0;
        case (i_op)
            CUR_ADVANCE: o_need_scroll = (r_row == L_ROW_LAST) && (r_col == L_COL_LAST);
            CUR_NEWLINE: o_need_scroll = (r_row == L_ROW_LAST);
            default:     o_need_scroll = 1'b0;
        endcase
    end

    assign o_lin_addr = AW'(r_row) * L_COLS_AW + AW'(r_col);
    assign o_row      = r_row;
    assign o_col      = r_col;

endmodule

// File: rtl/text_console.sv
// Byte-stream terminal front end: accepts characters, writes glyphs into TRAM,
// and performs scroll-up and clear-screen sequences on the TRAM port.
module text_console
    import video_pkg::*;
#(
    parameter int unsigned COLS       = video_pkg::COLS,
    parameter int unsigned ROWS       = video_pkg::ROWS,
    parameter logic [7:0]  FILL_CHAR  = 8'h20,
    parameter bit          CLR_ON_RST = 1'b1
) (
    input  logic                          sys_clk,
    input  logic                          rst_n,
    input  logic [7:0]                    char_data,
    input  logic                          char_valid,
    output logic                          char_ready,
    output logic [$clog2(ROWS*COLS)-1:0]  tram_addr,
    output logic [7:0]                    tram_wdata,
    output logic                          tram_wenable,
    input  logic [7:0]                    tram_rdata,
    output logic [4:0]                    cursor_row,
    output logic [6:0]                    cursor_col,
    output logic                          busy
);

    localparam int unsigned   AW          = $clog2(ROWS * COLS);
    localparam logic [AW-1:0] A_ONE       = AW'(1);
    localparam logic [AW-1:0] A_COLS      = AW'(COLS);
    localparam logic [AW-1:0] A_COPY_LAST = AW'((ROWS - 1) * COLS - 1);
    localparam logic [AW-1:0] A_LAST_ROW  = AW'((ROWS - 1) * COLS);
    localparam logic [AW-1:0] A_LAST      = AW'(ROWS * COLS - 1);

    state_e        r_state;
    logic [AW-1:0] r_cnt;
    logic          r_scroll;
    logic          r_ready;
    logic          r_busy;
    logic          r_wen;
    logic          r_fwd;
    logic [AW-1:0] r_addr;
    logic [7:0]    r_wdata;

    cursor_op_e    w_op;
    logic          w_accept;
    logic          w_need_scroll;
    logic [AW-1:0] w_lin;
    logic [4:0]    w_row;
    logic [6:0]    w_col;

    assign w_accept = char_valid & r_ready;

    console_cursor #(
        .COLS (COLS),
        .ROWS (ROWS),
        .AW   (AW)
    ) u_cursor (
        .i_clk         (sys_clk),
        .i_rst_n       (rst_n),
        .i_op          (w_op),
        .o_row         (w_row),
        .o_col         (w_col),
        .o_lin_addr    (w_lin),
        .o_need_scroll (w_need_scroll)
    );

    // Decode the accepted character into a cursor operation
    always_comb begin
        w_op = CUR_NONE;
        if (w_accept) begin
            case (char_data)
                CC_LF:   w_op = CUR_NEWLINE;
                CC_CR:   w_op = CUR_CR;
                CC_BS:   w_op = CUR_BACK;
                CC_FF:   w_op = CUR_HOME;
                default: w_op = CUR_ADVANCE;
            endcase
        end else begin
            w_op = CUR_NONE;
        end
    end

    // FSM, scroll/clear counter and TRAM port registers
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            r_state  <= CLR_ON_RST ? ST_CLEAR : ST_IDLE;
            r_cnt    <= '0;
            r_scroll <= 1'b0;
            r_ready  <= 1'b0;
            r_busy   <= CLR_ON_RST;
            r_wen    <= 1'b0;
            r_fwd    <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_wen   <= 1'b0;
                    r_fwd   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        r_ready  <= 1'b0;
                        r_scroll <= w_need_scroll;
                        r_addr   <= w_lin;
                        r_wdata  <= char_data;
                        r_state  <= ST_PUT;
                        case (char_data)
                            CC_LF, CC_CR: r_wen <= 1'b0;
                            CC_BS: begin
                                if (w_col != 7'd0) begin
                                    r_wen   <= 1'b1;
                                    r_addr  <= w_lin - A_ONE;
                                    r_wdata <= FILL_CHAR;
                                end
                            end
                            CC_FF: begin
                                r_busy  <= 1'b1;
                                r_cnt   <= '0;
                                r_state <= ST_CLEAR;
                            end
                            default: r_wen <= 1'b1;
                        endcase
                    end
                end
                ST_PUT: begin
                    r_wen <= 1'b0;
                    r_fwd <= 1'b0;
                    if (r_scroll) begin
                        // first read is issued here so the busy window is exactly two cycles per copied cell
                        r_addr  <= A_COLS;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_SCROLL_WR;
                    end else begin
                        r_ready <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                ST_SCROLL_RD: begin
                    r_addr  <= r_cnt + A_COLS;
                    r_wen   <= 1'b0;
                    r_fwd   <= 1'b0;
                    r_state <= ST_SCROLL_WR;
                end
                ST_SCROLL_WR: begin
                    r_addr <= r_cnt;
                    r_wen  <= 1'b1;
                    r_fwd  <= 1'b1;
                    if (r_cnt == A_COPY_LAST) begin
                        r_cnt   <= A_LAST_ROW;
                        r_state <= ST_CLEAR;
                    end else begin
                        r_cnt   <= r_cnt + A_ONE;
                        r_state <= ST_SCROLL_RD;
                    end
                end
                ST_CLEAR: begin
                    r_addr  <= r_cnt;
                    r_wen   <= 1'b1;
                    r_fwd   <= 1'b0;
                    r_wdata <= FILL_CHAR;
                    if (r_cnt == A_LAST) r_state <= ST_IDLE;
                    else                 r_cnt   <= r_cnt + A_ONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_wen   <= 1'b0;
                    r_fwd   <= 1'b0;
                end
            endcase
        end
    end

    assign char_ready   = r_ready;
    assign busy         = r_busy;
    assign tram_wenable = r_wen;
    assign tram_addr    = r_addr;
    // scroll writes pass through the RAM's own registered read data
    assign tram_wdata   = r_fwd ? tram_rdata : r_wdata;
    assign cursor_row   = w_row;
    assign cursor_col   = w_col;

endmodule

// File: tb/tb_text_console.sv
// Scoreboard bench for text_console: a bench-side screen model queues expected
// TRAM writes; a negedge monitor pops and compares each write the DUT issues.
module tb_text_console;

    localparam int NC = 80;
    localparam int NR = 30;
    localparam int NS = NC * NR;

    typedef struct packed {
        logic [11:0] a;
        logic [7:0]  d;
        logic        b;
    } wr_t;

    logic        sys_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  char_data = 8'h00;
    logic        char_valid = 1'b0;
    logic        char_ready;
    logic [11:0] tram_addr;
    logic [7:0]  tram_wdata;
    logic        tram_wenable;
    logic [7:0]  tram_rdata = 8'h00;
    logic [4:0]  cursor_row;
    logic [6:0]  cursor_col;
    logic        busy;

    logic [7:0]  mem [NS];
    logic [7:0]  img [NS];
    wr_t         exp_q [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          m_row = 0;
    int          m_col = 0;

    text_console dut (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n),
        .char_data    (char_data),
        .char_valid   (char_valid),
        .char_ready   (char_ready),
        .tram_addr    (tram_addr),
        .tram_wdata   (tram_wdata),
        .tram_wenable (tram_wenable),
        .tram_rdata   (tram_rdata),
        .cursor_row   (cursor_row),
        .cursor_col   (cursor_col),
        .busy         (busy)
    );

    always #5 sys_clk = ~sys_clk;

    // TRAM model with one-cycle registered read
    initial for (int i = 0; i < NS; i++) mem[i] = 8'hFF;
    always @(posedge sys_clk) begin
        if (tram_wenable) mem[tram_addr] <= tram_wdata;
        tram_rdata <= mem[tram_addr];
    end

    // Monitor: every write strobe is matched against the next expected write
    always @(negedge sys_clk) begin
        wr_t e;
        if (tram_wenable === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: addr=%0d data=%h busy=%b, none expected", tram_addr, tram_wdata, busy);
            end else begin
                e = exp_q.pop_front();
                if (tram_addr !== e.a || tram_wdata !== e.d || busy !== e.b) begin
                    n_bad++;
                    $display("FAIL tram_write: got addr=%0d data=%h busy=%b, need addr=%0d data=%h busy=%b",
                             tram_addr, tram_wdata, busy, e.a, e.d, e.b);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d need %0d", name, act, exp);
        end
    endtask

    task automatic push(input int a, input logic [7:0] d, input logic b);
        wr_t e;
        e.a = 12'(a);
        e.d = d;
        e.b = b;
        exp_q.push_back(e);
        img[a] = d;
    endtask

    task automatic model_clear_all();
        for (int i = 0; i < NS; i++) push(i, 8'h20, 1'b1);
        m_row = 0;
        m_col = 0;
    endtask

    task automatic model_newline();
        m_col = 0;
        if (m_row == NR - 1) begin
            for (int i = 0; i < NS - NC; i++) push(i, img[i + NC], 1'b1);
            for (int i = NS - NC; i < NS; i++) push(i, 8'h20, 1'b1);
        end else begin
            m_row++;
        end
    endtask

    task automatic model_char(input logic [7:0] c);
        case (c)
            8'h0A: model_newline();
            8'h0D: m_col = 0;
            8'h08: if (m_col > 0) begin
                m_col--;
                push(m_row * NC + m_col, 8'h20, 1'b0);
            end
            8'h0C: model_clear_all();
            default: begin
                push(m_row * NC + m_col, c, 1'b0);
                m_col++;
                if (m_col == NC) model_newline();
            end
        endcase
    endtask

    task automatic send(input logic [7:0] c, input bit chk_rdy);
        int n = 0;
        @(negedge sys_clk);
        while (char_ready !== 1'b1 && n < 10000) begin
            @(negedge sys_clk);
            n++;
        end
        if (char_ready !== 1'b1) begin
            check("send_ready_timeout", 0, 1);
        end else begin
            model_char(c);
            char_data  = c;
            char_valid = 1'b1;
            @(posedge sys_clk);
            #1;
            char_valid = 1'b0;
            char_data  = 8'h00;
            if (chk_rdy) begin
                @(negedge sys_clk);
                check("ready_low_t1", int'(char_ready), 0);
                @(negedge sys_clk);
                check("ready_high_t2", int'(char_ready), 1);
            end
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        @(negedge sys_clk);
        while (!(char_ready === 1'b1 && exp_q.size() == 0) && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        n_cmp++;
        if (!(char_ready === 1'b1 && exp_q.size() == 0)) begin
            n_bad++;
            $display("FAIL %s: ready=%b pending=%0d after %0d cycles", name, char_ready, exp_q.size(), n);
        end
    endtask

    task automatic check_cursor(input string name, input int r, input int c);
        check({name, "_row"}, int'(cursor_row), r);
        check({name, "_col"}, int'(cursor_col), c);
    endtask

    task automatic check_image(input string name);
        int bad = 0;
        for (int i = 0; i < NS; i++) if (mem[i] !== img[i]) bad++;
        check({name, "_bad_bytes"}, bad, 0);
    endtask

    initial begin
        int cnt;
        for (int i = 0; i < NS; i++) img[i] = 8'hFF;

        // reset values
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        check("rst_wen", int'(tram_wenable), 0);
        check("rst_addr", int'(tram_addr), 0);
        check("rst_wdata", int'(tram_wdata), 0);
        check("rst_ready", int'(char_ready), 0);
        check("rst_busy", int'(busy), 1);
        check_cursor("rst", 0, 0);

        // power-on clear
        model_clear_all();
        rst_n = 1'b1;
        wait_idle("init_clear", 3000);
        check("init_busy", int'(busy), 0);
        check_cursor("init", 0, 0);
        check_image("init_image");

        // "Hi"
        send(8'h48, 1'b1);
        send(8'h69, 1'b1);
        wait_idle("hi", 100);
        check_cursor("hi", 0, 2);

        // form feed, then a full line plus one
        send(8'h0C, 1'b0);
        wait_idle("ff", 3000);
        check_cursor("ff", 0, 0);
        for (int i = 0; i < NC; i++) send(8'h41, 1'b0);
        send(8'h42, 1'b0);
        wait_idle("line", 100);
        check_cursor("line", 1, 1);

        // move to (29,5) and scroll with LF
        for (int i = 0; i < 28; i++) send(8'h0A, 1'b0);
        for (int i = 0; i < 5; i++) send(8'h61 + 8'(i), 1'b0);
        wait_idle("pre_scroll", 100);
        check_cursor("pre_scroll", 29, 5);
        send(8'h0A, 1'b0);
        cnt = 0;
        for (int i = 0; i < 10 && busy !== 1'b1; i++) @(negedge sys_clk);
        while (busy === 1'b1 && cnt < 6000) begin
            cnt++;
            @(negedge sys_clk);
        end
        check("scroll_busy_cycles", cnt, 2 * (NR - 1) * NC + NC);
        wait_idle("scroll", 100);
        check_cursor("scroll", 29, 0);
        check_image("scroll_image");

        // backspace at col 3, then at col 0
        send(8'h78, 1'b0);
        send(8'h79, 1'b0);
        send(8'h7A, 1'b0);
        send(8'h08, 1'b0);
        wait_idle("bs", 100);
        check_cursor("bs", 29, 2);
        send(8'h0D, 1'b0);
        send(8'h08, 1'b0);
        wait_idle("bs0", 100);
        check_cursor("bs0", 29, 0);

        // printable at the last cell writes then scrolls
        for (int i = 0; i < NC - 1; i++) send(8'h71, 1'b0);
        wait_idle("fill_row", 100);
        check_cursor("fill_row", 29, 79);
        send(8'h57, 1'b0);
        wait_idle("last_cell", 6000);
        check_cursor("last_cell", 29, 0);
        check_image("last_cell_image");

        // reset in the middle of a scroll
        send(8'h0A, 1'b0);
        repeat (100) @(negedge sys_clk);
        @(posedge sys_clk);
        #1 rst_n = 1'b0;
        @(posedge sys_clk);
        #1 exp_q.delete();
        @(negedge sys_clk);
        check("midrst_wen", int'(tram_wenable), 0);
        check("midrst_busy", int'(busy), 1);
        check("midrst_ready", int'(char_ready), 0);
        check_cursor("midrst", 0, 0);
        model_clear_all();
        @(negedge sys_clk);
        rst_n = 1'b1;
        wait_idle("midrst_clear", 3000);
        send(8'h4F, 1'b0);
        send(8'h6B, 1'b0);
        wait_idle("ok", 100);
        check_cursor("ok", 0, 2);
        check_image("final_image");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
